video_ts_sched: RTL and testbench
=================================

# video_ts_sched

Task scheduler for the TS (tile/sprite) line renderer. It buffers render tasks from the tile/sprite fetch logic in a 4-entry FIFO and issues them to the renderer as single-cycle `tsr_go` strobes, back-to-back on `mem_rdy`. It also enforces a per-line DRAM word budget and reports per-line issue and overflow status to the video control registers.

## Interface
Parameters:
- `DEPTH_LOG`, 2: task FIFO depth is 2^DEPTH_LOG entries.
- `XMAX`, 9'd360: first invisible TS-line X coordinate; used by the clip option.

Ports:
- `clk` in 1: 28 MHz video clock.
- `reset` in 1: synchronous, active-high.
- `line_start` in 1: one-clk strobe at TS-line start.
- `budget` in 9: DRAM words available for TS on this line; sampled at `line_start`.
- `task_valid` in 1: upstream task present.
- `task_ready` out 1: FIFO can accept; a task is written when `task_valid && task_ready`.
- `task_last` in 1: marks the last task of the line.
- `task_x` in 9, `task_size` in 3, `task_flip` in 1, `task_addr` in 6, `task_line` in 9, `task_page` in 8, `task_pal` in 4: task fields.
- `mem_rdy` in 1: renderer ready.
- `tsr_go` out 1: renderer start strobe.
- `x_coord` out 9, `x_size` out 3, `flip` out 1, `addr` out 6, `line` out 9, `page` out 8, `pal` out 4: FIFO head fields, valid while `tsr_go` is high.
- `busy` out 1: state is RUN or DRAIN.
- `ovf` out 1: sticky per line; a task was dropped because the budget was exhausted.
- `issued` out 7: tasks issued on this line; saturates at 127.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `line_start`. Loads `rem <= budget`, clears `issued`, `ovf` and the FIFO.
  - RUN → DRAIN when a popped entry has `last` set.
  - DRAIN → DONE when `mem_rdy` is high and `tsr_go` is low.
  - DONE → IDLE next clock.
- `line_start` in any state forces the IDLE→RUN actions: FIFO flush, `rem` reload, counters cleared. This has priority over a same-cycle push or pop. A push in that cycle is discarded.
- Task cost is `2*(task_size+1)` words, computed in 5 bits (2..16).
- Pop condition in RUN: FIFO not empty.
  - If `mem_rdy` is high and cost ≤ `rem`: assert `tsr_go` (combinational) for that cycle, pop the head, decrement `rem` by cost, increment `issued`.
  - If cost > `rem`: pop without `tsr_go`, set `ovf`, and enter skip mode. In skip mode every later entry is popped without issue, one per clock, until `last` is popped. The renderer is not needed to discard entries.
- FIFO: registered storage with pointer and count. `task_ready = !full && state != DONE`. A simultaneous push and pop while full is not allowed because `task_ready` is low.
  - Upstream may push in IDLE; those tasks are flushed by the next `line_start`.
  - Push and pop in the same cycle with count 0 is not a bypass: the entry is visible one cycle later.
- Output fields come straight from the head entry. They are don't-care when `tsr_go` is low but must not glitch X; reset storage to 0.

## Timing
- Push to earliest `tsr_go`: 1 clk after the push cycle.
- Back-to-back issue: `tsr_go` may fire in the same cycle `mem_rdy` rises, which gives a continuous renderer stream. `mem_rdy` falls the cycle after `tsr_go`, so no double issue is possible. The block adds no guard register.
- Skip-mode drops run at 1 entry/clk.
- Reset values: `tsr_go`=0, `task_ready`=1, `busy`=0, `ovf`=0, `issued`=0, all field outputs 0, state IDLE, `rem`=0, FIFO empty.
- Reset mid-line aborts immediately. A renderer task already running completes on its own.

## Configuration
- `TS_SCHED_CLIP_EN` defined: at pop, a task whose span lies fully outside the visible area is popped without issue. It costs no budget, is not counted in `issued`, and does not set `ovf`.
  - `end = {1'b0,task_x} + {task_size,3'b111}` (10-bit).
  - Drop when `task_x >= XMAX && !end[9]`.
  - A span that wraps past 511 is issued.
- `TS_SCHED_CLIP_EN` not defined: every in-budget task is issued. `XMAX` is unused.

## Test plan
- Reset, then `line_start` with `budget`=64 and 3 tasks of `task_size`=0,1,3 with `last` on the third → 3 `tsr_go` strobes, each in the cycle `mem_rdy` is high; `issued`=3, `ovf`=0, final `rem`=64-2-4-8=50; FSM returns to IDLE after DRAIN.
- `budget`=10 and tasks of size 3 then 0 (with `last`) → first task issued (cost 8); second task (cost 2) issued, `rem`=0. Repeat with `budget`=9 → second task dropped, `ovf`=1, `issued`=1.
- 6 tasks pushed with `mem_rdy` held low → `task_ready` falls after 4 accepted; releasing `mem_rdy` drains the FIFO in order with fields matching the push order.
- `line_start` while 2 entries are queued and one task is being pushed → FIFO empty, `issued`=0, the pushed task lost, RUN entered.
- With `TS_SCHED_CLIP_EN`: `task_x`=400, size 0 → dropped, `rem` unchanged. `task_x`=508, size 1 (end=523) → issued. Without the macro both are issued.

Source files
------------

// File: rtl/video_ts_sched.sv
// video_ts_sched: TS line renderer task scheduler.
// Buffers render tasks in a small FIFO and issues them as tsr_go strobes
// on mem_rdy while enforcing a per-line DRAM word budget.
// Ports: clk, reset (sync, active-high), line_start/budget (line control),
//   task_* (upstream push, task_valid/task_ready handshake), mem_rdy,
//   tsr_go plus head fields (renderer), busy/ovf/issued (status).
// Option: TS_SCHED_CLIP_EN drops tasks whose span lies fully past XMAX.
module video_ts_sched #(
   parameter int         DEPTH_LOG = 2,
   parameter logic [8:0] XMAX      = 9'd360
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       line_start,
   input  logic [8:0] budget,
   input  logic       task_valid,
   output logic       task_ready,
   input  logic       task_last,
   input  logic [8:0] task_x,
   input  logic [2:0] task_size,
   input  logic       task_flip,
   input  logic [5:0] task_addr,
   input  logic [8:0] task_line,
   input  logic [7:0] task_page,
   input  logic [3:0] task_pal,
   input  logic       mem_rdy,
   output logic       tsr_go,
   output logic [8:0] x_coord,
   output logic [2:0] x_size,
   output logic       flip,
   output logic [5:0] addr,
   output logic [8:0] line,
   output logic [7:0] page,
   output logic [3:0] pal,
   output logic       busy,
   output logic       ovf,
   output logic [6:0] issued
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] CNT_FULL = {1'b1, {DEPTH_LOG{1'b0}}};

`ifdef TS_SCHED_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   typedef struct packed {
      logic       last;
      logic [8:0] x;
      logic [2:0] size;
      logic       flip;
      logic [5:0] addr;
      logic [8:0] line;
      logic [7:0] page;
      logic [3:0] pal;
   } ent_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t               state;
   ent_t                 mem [DEPTH];
   logic [DEPTH_LOG-1:0] wptr;
   logic [DEPTH_LOG-1:0] rptr;
   logic [DEPTH_LOG:0]   count;
   logic [8:0]           rem;
   logic                 skip;

   ent_t       head;
   ent_t       wr_ent;
   logic       empty;
   logic       full;
   logic       push;
   logic       pop;
   logic [4:0] cost;
   logic       fits;
   logic       drop_clip;
   logic       go;

   assign head  = mem[rptr];
   assign empty = (count == '0);
   assign full  = (count == CNT_FULL);

   assign wr_ent.last = task_last;
   assign wr_ent.x    = task_x;
   assign wr_ent.size = task_size;
   assign wr_ent.flip = task_flip;
   assign wr_ent.addr = task_addr;
   assign wr_ent.line = task_line;
   assign wr_ent.page = task_page;
   assign wr_ent.pal  = task_pal;

   // cost = 2*(size+1) words, 2..16
   assign cost = {1'b0, head.size, 1'b0} + 5'd2;
   assign fits = ({4'b0, cost} <= rem);

   // Span end past 511 wraps onto the visible area, so it is kept.
   assign drop_clip = CLIP_EN && (head.x >= XMAX) &&
      (({1'b0, head.x} + {4'b0, head.size, 3'b111}) < 10'd512);

   // A head entry leaves the FIFO when skipped, clipped, over budget,
   // or issued; only the issue case waits for the renderer.
   assign pop = (state == RUN) && !empty &&
      (skip || drop_clip || !fits || mem_rdy);

   assign go = (state == RUN) && !empty && !skip && !drop_clip &&
      fits && mem_rdy && !line_start && !reset;

   assign push       = task_valid && task_ready;
   assign task_ready = !full && (state != DONE);
   assign tsr_go     = go;
   assign busy       = (state == RUN) || (state == DRAIN);

   assign x_coord = head.x;
   assign x_size  = head.size;
   assign flip    = head.flip;
   assign addr    = head.addr;
   assign line    = head.line;
   assign page    = head.page;
   assign pal     = head.pal;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         rem    <= '0;
         skip   <= 1'b0;
         ovf    <= 1'b0;
         issued <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (line_start) begin
         // New line wins over any same-cycle push or pop.
         state  <= RUN;
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         rem    <= budget;
         skip   <= 1'b0;
         ovf    <= 1'b0;
         issued <= '0;
      end else begin
         if (push) begin
            mem[wptr] <= wr_ent;
            wptr      <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end

         unique case (state)
            RUN: begin
               if (pop) begin
                  if (go) begin
                     rem <= rem - {4'b0, cost};
                     if (issued != 7'd127) begin
                        issued <= issued + 7'd1;
                     end
                  end else if (!skip && !drop_clip) begin
                     // Over budget: drop the rest of the line.
                     ovf  <= 1'b1;
                     skip <= 1'b1;
                  end
                  if (head.last) begin
                     state <= DRAIN;
                     skip  <= 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (mem_rdy) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_ts_sched.sv
// tb_video_ts_sched: directed plus randomized bench for video_ts_sched.
// A queue-based line model is compared against the DUT every cycle.
module tb_video_ts_sched;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       line_start = 1'b0;
   logic [8:0] budget = '0;
   logic       task_valid = 1'b0;
   logic       task_ready;
   logic       task_last = 1'b0;
   logic [8:0] task_x = '0;
   logic [2:0] task_size = '0;
   logic       task_flip = 1'b0;
   logic [5:0] task_addr = '0;
   logic [8:0] task_line = '0;
   logic [7:0] task_page = '0;
   logic [3:0] task_pal = '0;
   logic       mem_rdy = 1'b0;
   logic       tsr_go;
   logic [8:0] x_coord;
   logic [2:0] x_size;
   logic       flip;
   logic [5:0] addr;
   logic [8:0] line;
   logic [7:0] page;
   logic [3:0] pal;
   logic       busy;
   logic       ovf;
   logic [6:0] issued;

   video_ts_sched dut (
      .clk        (clk),
      .reset      (reset),
      .line_start (line_start),
      .budget     (budget),
      .task_valid (task_valid),
      .task_ready (task_ready),
      .task_last  (task_last),
      .task_x     (task_x),
      .task_size  (task_size),
      .task_flip  (task_flip),
      .task_addr  (task_addr),
      .task_line  (task_line),
      .task_page  (task_page),
      .task_pal   (task_pal),
      .mem_rdy    (mem_rdy),
      .tsr_go     (tsr_go),
      .x_coord    (x_coord),
      .x_size     (x_size),
      .flip       (flip),
      .addr       (addr),
      .line       (line),
      .page       (page),
      .pal        (pal),
      .busy       (busy),
      .ovf        (ovf),
      .issued     (issued)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors = 0;
   int gos = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Line model: phase of the line, pending tasks, remaining words.
   localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3;

   typedef struct {
      int x, size, flip, addr, line, page, pal, last;
   } mtask_t;

   mtask_t q[$];
   mtask_t h;
   int     ph = P_IDLE;
   int     m_rem = 0;
   int     m_issued = 0;
   bit     m_ovf = 0;
   bit     m_skip = 0;
   bit     e_go, e_rdy, m_pop, h_clip, h_fit;
   int     cost;

   function automatic bit clipped(int x, int size);
`ifdef TS_SCHED_CLIP_EN
      return (x >= 360) && (x + size * 8 + 7 < 512);
`else
      return 1'b0;
`endif
   endfunction

   always @(negedge clk) begin
      e_rdy = (q.size() < 4) && (ph != P_DONE);
      e_go  = 1'b0;
      m_pop = 1'b0;
      h_clip = 1'b0;
      h_fit = 1'b0;
      cost = 0;
      if (ph == P_RUN && q.size() > 0) begin
         h      = q[0];
         cost   = 2 * (h.size + 1);
         h_clip = clipped(h.x, h.size);
         h_fit  = cost <= m_rem;
         m_pop  = m_skip || h_clip || !h_fit || mem_rdy;
         e_go   = !m_skip && !h_clip && h_fit && mem_rdy &&
                  !line_start && !reset;
      end

      check("tsr_go", 32'(tsr_go), 32'(e_go));
      check("task_ready", 32'(task_ready), 32'(e_rdy));
      check("busy", 32'(busy), 32'(ph == P_RUN || ph == P_DRAIN));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("issued", 32'(issued), 32'(m_issued));
      if (e_go) begin
         check("x_coord", 32'(x_coord), 32'(h.x));
         check("x_size", 32'(x_size), 32'(h.size));
         check("flip", 32'(flip), 32'(h.flip));
         check("addr", 32'(addr), 32'(h.addr));
         check("line", 32'(line), 32'(h.line));
         check("page", 32'(page), 32'(h.page));
         check("pal", 32'(pal), 32'(h.pal));
      end
      if (tsr_go === 1'b1) gos++;

      if (reset) begin
         q.delete();
         ph = P_IDLE;
         m_rem = 0;
         m_issued = 0;
         m_ovf = 0;
         m_skip = 0;
      end else if (line_start) begin
         q.delete();
         ph = P_RUN;
         m_rem = budget;
         m_issued = 0;
         m_ovf = 0;
         m_skip = 0;
      end else begin
         if (m_pop) begin
            void'(q.pop_front());
            if (e_go) begin
               m_rem -= cost;
               if (m_issued < 127) m_issued++;
            end else if (!m_skip && !h_clip) begin
               m_ovf = 1;
               m_skip = 1;
            end
            if (h.last != 0) begin
               ph = P_DRAIN;
               m_skip = 0;
            end
         end else if (ph == P_DRAIN) begin
            if (mem_rdy) ph = P_DONE;
         end else if (ph == P_DONE) begin
            ph = P_IDLE;
         end
         if (task_valid && e_rdy) begin
            q.push_back('{x: task_x, size: task_size, flip: task_flip,
                          addr: task_addr, line: task_line,
                          page: task_page, pal: task_pal,
                          last: task_last});
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_in();
      line_start = 1'b0;
      task_valid = 1'b0;
      task_last  = 1'b0;
   endtask

   task automatic set_task(input int x, input int size, input bit last);
      task_valid = 1'b1;
      task_x     = 9'(x);
      task_size  = 3'(size);
      task_last  = last;
      task_flip  = 1'($urandom);
      task_addr  = 6'($urandom);
      task_line  = 9'($urandom);
      task_page  = 8'($urandom);
      task_pal   = 4'($urandom);
   endtask

   task automatic start_line(input int b);
      line_start = 1'b1;
      budget     = 9'(b);
      task_valid = 1'b0;
      tick();
      line_start = 1'b0;
   endtask

   int g0;
   int acc;
   int r;

   initial begin
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      idle_in();
      check("rst task_ready", 32'(task_ready), 32'd1);
      check("rst tsr_go", 32'(tsr_go), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst ovf", 32'(ovf), 32'd0);
      check("rst issued", 32'(issued), 32'd0);
      check("rst x_coord", 32'(x_coord), 32'd0);
      check("rst page", 32'(page), 32'd0);
      check("rst pal", 32'(pal), 32'd0);

      // Three tasks within budget, renderer always ready.
      mem_rdy = 1'b1;
      g0 = gos;
      start_line(64);
      set_task(10, 0, 0); tick();
      set_task(20, 1, 0); tick();
      set_task(30, 3, 1); tick();
      idle_in();
      tick(8);
      check("t1 go count", 32'(gos - g0), 32'd3);
      check("t1 issued", 32'(issued), 32'd3);
      check("t1 ovf", 32'(ovf), 32'd0);
      check("t1 model rem", 32'(m_rem), 32'd50);
      check("t1 idle", 32'(busy), 32'd0);

      // Budget exactly spent.
      start_line(10);
      set_task(40, 3, 0); tick();
      set_task(50, 0, 1); tick();
      idle_in();
      tick(6);
      check("t2a issued", 32'(issued), 32'd2);
      check("t2a ovf", 32'(ovf), 32'd0);
      check("t2a model rem", 32'(m_rem), 32'd0);

      // One word short: second task dropped.
      start_line(9);
      set_task(40, 3, 0); tick();
      set_task(50, 0, 1); tick();
      idle_in();
      tick(6);
      check("t2b issued", 32'(issued), 32'd1);
      check("t2b ovf", 32'(ovf), 32'd1);
      check("t2b model rem", 32'(m_rem), 32'd1);

      // FIFO fills with the renderer stalled, then drains in order.
      mem_rdy = 1'b0;
      start_line(200);
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         set_task(100 + k, k % 4, k == 3);
         if (task_ready) acc++;
         tick();
      end
      idle_in();
      check("t3 accepted", 32'(acc), 32'd4);
      check("t3 ready low", 32'(task_ready), 32'd0);
      mem_rdy = 1'b1;
      tick(10);
      check("t3 issued", 32'(issued), 32'd4);

      // New line discards queued and in-flight tasks.
      mem_rdy = 1'b0;
      start_line(50);
      set_task(60, 0, 0); tick();
      set_task(61, 0, 0); tick();
      set_task(77, 1, 1);
      line_start = 1'b1;
      budget = 9'd40;
      tick();
      idle_in();
      check("t4 issued", 32'(issued), 32'd0);
      check("t4 busy", 32'(busy), 32'd1);
      check("t4 ready", 32'(task_ready), 32'd1);
      check("t4 model empty", 32'(q.size()), 32'd0);
      mem_rdy = 1'b1;
      g0 = gos;
      tick(3);
      check("t4 no go", 32'(gos - g0), 32'd0);

      // Clip boundary cases.
      start_line(64);
      set_task(400, 0, 0); tick();
      set_task(508, 1, 1); tick();
      idle_in();
      tick(6);
`ifdef TS_SCHED_CLIP_EN
      check("t5 issued", 32'(issued), 32'd1);
      check("t5 model rem", 32'(m_rem), 32'd60);
`else
      check("t5 issued", 32'(issued), 32'd2);
      check("t5 model rem", 32'(m_rem), 32'd58);
`endif
      check("t5 ovf", 32'(ovf), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         reset      = ($urandom % 900) == 0;
         line_start = ($urandom % 40) == 0;
         budget     = 9'($urandom % 120);
         mem_rdy    = ($urandom % 4) != 0;
         r = int'($urandom % 4);
         case (r)
            0: set_task(int'($urandom % 512), int'($urandom % 8), 0);
            1: set_task(360 + int'($urandom % 152), int'($urandom % 8), 0);
            2: set_task(500 + int'($urandom % 12), int'($urandom % 8), 0);
            default: set_task(int'($urandom % 360), int'($urandom % 8), 0);
         endcase
         task_last  = ($urandom % 5) == 0;
         task_valid = ($urandom % 10) < 6;
         tick();
      end
      reset = 1'b0;
      idle_in();
      tick(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
